apple2_track_writeback: RTL and testbench

// - Writes a modified 13-sector NIB track from the shared track RAM back to the mounted SD image via hps_io sd_wr.
// - Write-direction counterpart of the track loader. Sits in emu beside the loader and shares the track RAM read port and the hps_io sd_* channel.
// - Flushes on loader request (before a track change), on an idle timeout, or never for read-only or absent images.

---
 rtl/apple2_disk_pkg.sv | 10 +
 rtl/apple2_track_writeback.sv | 146 ++++++++++++++
 tb/tb_apple2_track_writeback.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/apple2_disk_pkg.sv
// apple2_disk_pkg: Disk II NIB track geometry, writeback state encoding and track-to-LBA helper
package apple2_disk_pkg;
  localparam int SECTORS      = 13;
  localparam int SECTOR_BYTES = 512;
  localparam int TRACK_W      = 6;
  typedef enum logic {IDLE, WRITE} wb_state_e;
  function automatic logic [31:0] track_lba(input logic [TRACK_W-1:0] track);
    return 32'(SECTORS) * {{(32-TRACK_W){1'b0}}, track};
  endfunction
endpackage

// File: rtl/apple2_track_writeback.sv
// apple2_track_writeback: flushes a modified NIB track from track RAM back to the SD image via hps_io sd_wr
module apple2_track_writeback
  import apple2_disk_pkg::*;
#(
  parameter int unsigned IDLE_FLUSH = 7159090
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [TRACK_W-1:0] track,
  input  logic               track_we,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               flush_done,
  output logic               cpu_wait,
  output logic [31:0]        sd_lba,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  output logic [12:0]        track_ram_addr,
  input  logic [7:0]         track_ram_dout,
  output logic [7:0]         sd_buff_din
);
  localparam int CNT_W = 24;
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(IDLE_FLUSH - 1);
  wb_state_e state_q, state_d;
  logic dirty_q, dirty_d, redo_q, redo_d, req_q, req_d, loader_q, loader_d, old_ack_q;
  logic flush_busy_q, flush_busy_d, flush_done_q, flush_done_d;
  logic cpu_wait_q, cpu_wait_d, sd_wr_q, sd_wr_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic [TRACK_W-1:0] dirty_track_q, dirty_track_d;
  logic [3:0] sec_q, sec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic discard, ack_rise, ack_fall, timeout, req;
  assign discard  = img_mounted | ~img_present | img_readonly;
  assign ack_rise = sd_ack & ~old_ack_q;
  assign ack_fall = ~sd_ack & old_ack_q;
  assign timeout  = (IDLE_FLUSH != 0) && dirty_q && (cnt_q >= TO_LIM);
  assign req      = flush_req | req_q;
  assign track_ram_addr = {sec_q, sd_buff_addr};
  assign sd_buff_din    = track_ram_dout;
  assign flush_busy = flush_busy_q;
  assign flush_done = flush_done_q;
  assign cpu_wait   = cpu_wait_q;
  assign sd_lba     = sd_lba_q;
  assign sd_wr      = sd_wr_q;
  always_comb begin
    state_d       = state_q;
    dirty_d       = dirty_q;
    redo_d        = redo_q;
    req_d         = req_q;
    loader_d      = loader_q;
    dirty_track_d = dirty_track_q;
    sec_d         = sec_q;
    sd_lba_d      = sd_lba_q;
    sd_wr_d       = sd_wr_q;
    cpu_wait_d    = cpu_wait_q;
    flush_busy_d  = flush_busy_q;
    flush_done_d  = 1'b0;
    cnt_d = track_we ? '0 : (dirty_q && state_q == IDLE && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    if (discard) begin
      state_d      = IDLE;
      dirty_d      = 1'b0;
      redo_d       = 1'b0;
      req_d        = 1'b0;
      sd_wr_d      = 1'b0;
      cpu_wait_d   = 1'b0;
      flush_busy_d = 1'b0;
      flush_done_d = (state_q == IDLE) && flush_req;
    end else if (state_q == IDLE) begin
      if (track_we && !dirty_q) begin
        dirty_d       = 1'b1;
        dirty_track_d = track;
      end
      if (dirty_q && (req || timeout)) begin
        state_d      = WRITE;
        sec_d        = '0;
        sd_lba_d     = track_lba(dirty_track_q);
        sd_wr_d      = 1'b1;
        cpu_wait_d   = 1'b1;
        flush_busy_d = 1'b1;
        dirty_d      = 1'b0;
        loader_d     = req;
        req_d        = 1'b0;
      end else if (req) begin
        flush_done_d = 1'b1;
        req_d        = 1'b0;
      end
    end else begin
      // Late loader requests wait for this transfer; writes during it re-dirty the track
      req_d      = req;
      redo_d     = redo_q | track_we;
      cpu_wait_d = 1'b1;
      if (ack_rise) begin
        sd_wr_d  = (sec_q >= 4'(SECTORS - 1)) ? 1'b0 : sd_wr_q;
        sd_lba_d = sd_lba_q + 32'd1;
      end
      if (ack_fall) begin
        sec_d      = sec_q + 4'd1;
        cpu_wait_d = 1'b0;
        if (!sd_wr_q) begin
          state_d      = IDLE;
          flush_busy_d = 1'b0;
          flush_done_d = loader_q;
          dirty_d      = redo_q | track_we;
          redo_d       = 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      dirty_q       <= 1'b0;
      redo_q        <= 1'b0;
      req_q         <= 1'b0;
      loader_q      <= 1'b0;
      old_ack_q     <= 1'b0;
      dirty_track_q <= '0;
      sec_q         <= '0;
      sd_lba_q      <= '0;
      sd_wr_q       <= 1'b0;
      cpu_wait_q    <= 1'b0;
      flush_busy_q  <= 1'b0;
      flush_done_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      dirty_q       <= dirty_d;
      redo_q        <= redo_d;
      req_q         <= req_d;
      loader_q      <= loader_d;
      old_ack_q     <= sd_ack;
      dirty_track_q <= dirty_track_d;
      sec_q         <= sec_d;
      sd_lba_q      <= sd_lba_d;
      sd_wr_q       <= sd_wr_d;
      cpu_wait_q    <= cpu_wait_d;
      flush_busy_q  <= flush_busy_d;
      flush_done_q  <= flush_done_d;
      cnt_q         <= cnt_d;
    end
  end
endmodule

// File: tb/tb_apple2_track_writeback.sv
// tb_apple2_track_writeback: directed checks of the track writeback against a small hps_io/track RAM model
module tb_apple2_track_writeback;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  track = '0;
  logic        track_we = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_present = 1'b1;
  logic        img_readonly = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_busy, flush_done, cpu_wait, sd_wr;
  logic [31:0] sd_lba;
  logic        sd_ack = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [12:0] track_ram_addr;
  logic [7:0]  track_ram_dout = '0;
  logic [7:0]  sd_buff_din;
  logic [7:0]  ram [0:8191];
  logic [7:0]  cap [0:8191];
  logic [31:0] lba_log [0:15];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  apple2_track_writeback #(.IDLE_FLUSH(100)) dut (
    .clk_sys(clk_sys), .reset(reset), .track(track), .track_we(track_we),
    .img_mounted(img_mounted), .img_present(img_present), .img_readonly(img_readonly),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .cpu_wait(cpu_wait), .sd_lba(sd_lba), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .track_ram_addr(track_ram_addr),
    .track_ram_dout(track_ram_dout), .sd_buff_din(sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) track_ram_dout <= ram[track_ram_addr];
  always @(negedge clk_sys) begin
    if (flush_done) done_cnt++;
    if (sd_wr) wr_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_we(input logic [5:0] t);
    track = t;
    track_we = 1'b1;
    tick;
    track_we = 1'b0;
  endtask

  task automatic pulse_req;
    flush_req = 1'b1;
    tick;
    flush_req = 1'b0;
  endtask

  task automatic kill;
    img_mounted = 1'b1;
    tick;
    img_mounted = 1'b0;
  endtask

  task automatic wait_wr(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (!sd_wr && n < 300);
  endtask

  // hps_io model: one sector per ack, each byte address held two cycles
  task automatic host(input int redo_sec, input int abort_sec, input int abort_kind, output int nsec);
    int g;
    nsec = 0;
    g = 0;
    while (!sd_wr && g < 300) begin
      tick;
      g++;
    end
    check("host_wr_seen", 32'(sd_wr), 1);
    while (sd_wr && nsec < 16) begin
      lba_log[nsec] = sd_lba;
      sd_ack = 1'b1;
      for (int a = 0; a < 512; a++) begin
        sd_buff_addr = 9'(a);
        if (nsec == redo_sec && a == 100) track_we = 1'b1;
        tick;
        track_we = 1'b0;
        tick;
        cap[nsec*512+a] = sd_buff_din;
        if (nsec == abort_sec && a == 100) begin
          if (abort_kind == 1) img_mounted = 1'b1;
          else reset = 1'b1;
          tick;
          img_mounted = 1'b0;
          reset = 1'b0;
          check("abort_sd_wr", 32'(sd_wr), 0);
          check("abort_busy", 32'(flush_busy), 0);
          check("abort_cpu_wait", 32'(cpu_wait), 0);
          sd_ack = 1'b0;
          tick;
          return;
        end
      end
      sd_ack = 1'b0;
      tick;
      nsec++;
      if (nsec == 1) check("cpu_wait_gap", 32'(cpu_wait), 0);
      if (sd_wr) begin
        tick;
        if (nsec == 1) check("cpu_wait_back", 32'(cpu_wait), 1);
      end
    end
  endtask

  initial begin
    int n, d0, w0, bad;
    for (int i = 0; i < 8192; i++) ram[i] = 8'((i * 37) ^ (i >> 8));
    repeat (3) tick;
    check("rst_sd_wr", 32'(sd_wr), 0);
    check("rst_busy", 32'(flush_busy), 0);
    check("rst_done", 32'(flush_done), 0);
    check("rst_cpu_wait", 32'(cpu_wait), 0);
    check("rst_lba", sd_lba, 0);
    reset = 1'b0;
    tick;
    // clean flush request
    w0 = wr_cnt;
    pulse_req;
    check("clean_done", 32'(flush_done), 1);
    tick;
    check("clean_done_pulse", 32'(flush_done), 0);
    check("clean_no_wr", 32'(wr_cnt - w0), 0);
    // loader flush of track 5
    pulse_we(6'd5);
    d0 = done_cnt;
    pulse_req;
    check("ld_sd_wr", 32'(sd_wr), 1);
    check("ld_lba0", sd_lba, 65);
    check("ld_cpu_wait", 32'(cpu_wait), 1);
    check("ld_busy", 32'(flush_busy), 1);
    host(-1, -1, 0, n);
    tick;
    check("ld_sectors", 32'(n), 13);
    bad = 0;
    for (int i = 0; i < 13; i++) if (lba_log[i] != 32'(65 + i)) bad++;
    check("ld_lba_seq", 32'(bad), 0);
    check("ld_lba_last", lba_log[12], 77);
    bad = 0;
    for (int i = 0; i < 6656; i++) if (cap[i] !== ram[i]) bad++;
    check("ld_data", 32'(bad), 0);
    check("ld_done_once", 32'(done_cnt - d0), 1);
    check("ld_cpu_wait_end", 32'(cpu_wait), 0);
    check("ld_busy_end", 32'(flush_busy), 0);
    // idle timeout
    pulse_we(6'd2);
    wait_wr(n);
    check("to_cycles", 32'(n), 100);
    check("to_lba", sd_lba, 26);
    kill;
    pulse_we(6'd2);
    repeat (49) tick;
    check("to_restart_quiet", 32'(sd_wr), 0);
    pulse_we(6'd2);
    wait_wr(n);
    check("to_restart_cycles", 32'(n), 100);
    kill;
    // live track moves before flush
    pulse_we(6'd3);
    track = 6'd4;
    pulse_req;
    check("live_lba", sd_lba, 39);
    kill;
    // re-dirty during sector 7
    pulse_we(6'd6);
    d0 = done_cnt;
    pulse_req;
    host(7, -1, 0, n);
    check("redo_sectors", 32'(n), 13);
    wait_wr(n);
    check("redo_second_flush", 32'(n), 100);
    check("redo_lba", sd_lba, 78);
    check("redo_done_once", 32'(done_cnt - d0), 1);
    kill;
    // read-only image
    img_readonly = 1'b1;
    w0 = wr_cnt;
    pulse_we(6'd1);
    repeat (150) tick;
    check("ro_no_wr", 32'(wr_cnt - w0), 0);
    pulse_req;
    check("ro_done", 32'(flush_done), 1);
    img_readonly = 1'b0;
    tick;
    // abort by mount, then by reset, during sector 4
    for (int k = 1; k <= 2; k++) begin
      pulse_we(6'd7);
      d0 = done_cnt;
      pulse_req;
      host(-1, 4, k, n);
      tick;
      check("abort_no_done", 32'(done_cnt - d0), 0);
      w0 = wr_cnt;
      repeat (150) tick;
      check("abort_clean", 32'(wr_cnt - w0), 0);
      pulse_req;
      check("abort_idle_done", 32'(flush_done), 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
